// File: rtl/fp_div_goldschmidt_iter.sv
// fp_div_goldschmidt_iter: iterative IEEE-754 divider q = a / b (Goldschmidt).
// Sequence IDLE -> ITER -> NORM -> IDLE. Fixed latency is ITERS+2 cycles.
// Optional macro FPDIV_EARLY_OUT_EN lets special operands finish one cycle
// after start. Without it, every operation takes the full latency.
// Internal fixed point: WORK_W bits with 2 integer bits and F = WORK_W-2
// fraction bits, so iterates up to just under 4.0 are representable.
module fp_div_goldschmidt_iter #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int ITERS  = 5,
  parameter int WORK_W = FRAC_W + 11,
  parameter int CNT_W  = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic [EXP_W+FRAC_W:0]   q,
  output logic                    busy,
  output logic                    ready,
  output logic [CNT_W-1:0]        count,
  output logic [3:0]              flags,
  output logic [WORK_W-1:0]       reg_a,
  output logic [WORK_W-1:0]       reg_b
);

  localparam int W       = 1 + EXP_W + FRAC_W;
  localparam int F       = WORK_W - 2;
  localparam int E_W     = EXP_W + 2;
  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [WORK_W-1:0]       TWO       = {2'b10, {F{1'b0}}};
  // Half of a quarter-ulp below the final truncation point: lifts the
  // always-low Goldschmidt estimate back over exact quotients.
  localparam logic [WORK_W-1:0]       RND       = WORK_W'(1) << (F - FRAC_W - 3);
  localparam logic signed [E_W-1:0]   BIAS_E    = E_W'(BIAS);
  localparam logic signed [E_W-1:0]   EXP_MAX_E = E_W'(EXP_MAX);
  localparam logic [CNT_W-1:0]        ITERS_C   = CNT_W'(ITERS);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_NORM} state_t;

  // Mantissa {1,frac} placed in [0.5,1) of the working format.
  function automatic logic [WORK_W-1:0] scale_f(input logic [FRAC_W-1:0] frac);
    scale_f = {2'b00, 1'b1, frac, {(F - FRAC_W - 1){1'b0}}};
  endfunction

  // Special-operand decode: {is_special, flags[3:0], result}. Denormals count as zero.
  function automatic logic [W+4:0] special_f(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    logic a_ones, b_ones, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, sgn;
    logic [W-1:0] nan_v, inf_v, zero_v;
    a_ones = &op_a[W-2:FRAC_W];
    b_ones = &op_b[W-2:FRAC_W];
    a_zero = ~(|op_a[W-2:FRAC_W]);
    b_zero = ~(|op_b[W-2:FRAC_W]);
    a_nan  = a_ones & (|op_a[FRAC_W-1:0]);
    b_nan  = b_ones & (|op_b[FRAC_W-1:0]);
    a_inf  = a_ones & ~(|op_a[FRAC_W-1:0]);
    b_inf  = b_ones & ~(|op_b[FRAC_W-1:0]);
    sgn    = op_a[W-1] ^ op_b[W-1];
    nan_v  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};
    inf_v  = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    zero_v = {sgn, {(W - 1){1'b0}}};
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      special_f = {1'b1, 4'b1000, nan_v};
    end else if (b_zero & ~a_inf) begin
      special_f = {1'b1, 4'b0100, inf_v};
    end else if (a_inf) begin
      special_f = {1'b1, 4'b0000, inf_v};
    end else if (b_inf | a_zero) begin
      special_f = {1'b1, 4'b0000, zero_v};
    end else begin
      special_f = {1'b0, 4'b0000, {W{1'b0}}};
    end
  endfunction

  state_t              state_q, state_d;
  logic [W-1:0]        opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]        q_q, q_d;
  logic                busy_q, busy_d, ready_q, ready_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [3:0]          flags_q, flags_d;
  logic [WORK_W-1:0]   reg_a_q, reg_a_d, reg_b_q, reg_b_d;

  logic [WORK_W-1:0]   x_s, mul_a_s, mul_b_s, qb_s, norm_s;
  logic [FRAC_W-1:0]   frac_s;
  logic                shift_s, sign_s, ovf_s, unf_s;
  logic signed [E_W-1:0] ea_s, eb_s, e_s;
  logic [W+4:0]        spec_norm_s;
`ifdef FPDIV_EARLY_OUT_EN
  logic [W+4:0]        spec_in_s;
`endif

  // Datapath: one Goldschmidt step, then bias/normalise/exponent for NORM.
  always_comb begin
    x_s     = TWO - reg_b_q;
    mul_a_s = WORK_W'(({{WORK_W{1'b0}}, reg_a_q} * {{WORK_W{1'b0}}, x_s}) >> F);
    mul_b_s = WORK_W'(({{WORK_W{1'b0}}, reg_b_q} * {{WORK_W{1'b0}}, x_s}) >> F);
    qb_s    = reg_a_q + RND;
    shift_s = ~qb_s[F];
    norm_s  = shift_s ? (qb_s << 1) : qb_s;
    frac_s  = FRAC_W'(norm_s >> (F - FRAC_W));
    ea_s    = {2'b00, opa_q[W-2:FRAC_W]};
    eb_s    = {2'b00, opb_q[W-2:FRAC_W]};
    e_s     = ea_s - eb_s + BIAS_E - $signed({{(E_W - 1){1'b0}}, shift_s});
    sign_s  = opa_q[W-1] ^ opb_q[W-1];
    ovf_s   = (e_s >= EXP_MAX_E);
    unf_s   = e_s[E_W-1] | (e_s == {E_W{1'b0}});
    spec_norm_s = special_f(opa_q, opb_q);
`ifdef FPDIV_EARLY_OUT_EN
    spec_in_s   = special_f(a, b);
`endif
  end

  // Next-state and register updates for the IDLE/ITER/NORM sequence.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    q_d     = q_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    count_d = count_q;
    flags_d = flags_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          flags_d = 4'b0000;
          count_d = {CNT_W{1'b0}};
          busy_d  = 1'b1;
`ifdef FPDIV_EARLY_OUT_EN
          if (spec_in_s[W+4]) begin
            state_d = S_NORM;
          end else begin
            reg_a_d = scale_f(a[FRAC_W-1:0]);
            reg_b_d = scale_f(b[FRAC_W-1:0]);
            state_d = S_ITER;
          end
`else
          reg_a_d = scale_f(a[FRAC_W-1:0]);
          reg_b_d = scale_f(b[FRAC_W-1:0]);
          state_d = S_ITER;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        if (count_q == ITERS_C) begin
          state_d = S_NORM;
        end else begin
          reg_a_d = mul_a_s;
          reg_b_d = mul_b_s;
          count_d = count_q + CNT_W'(1);
        end
      end
      S_NORM: begin
        if (spec_norm_s[W+4]) begin
          q_d     = spec_norm_s[W-1:0];
          flags_d = spec_norm_s[W+3:W];
        end else if (ovf_s) begin
          q_d     = {sign_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          flags_d = 4'b0010;
        end else if (unf_s) begin
          q_d     = {sign_s, {(W - 1){1'b0}}};
          flags_d = 4'b0001;
        end else begin
          q_d     = {sign_s, e_s[EXP_W-1:0], frac_s};
          flags_d = 4'b0000;
        end
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= {W{1'b0}};
      opb_q   <= {W{1'b0}};
      q_q     <= {W{1'b0}};
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      count_q <= {CNT_W{1'b0}};
      flags_q <= 4'b0000;
      reg_a_q <= {WORK_W{1'b0}};
      reg_b_q <= {WORK_W{1'b0}};
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      count_q <= count_d;
      flags_q <= flags_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
    end
  end

  assign q     = q_q;
  assign busy  = busy_q;
  assign ready = ready_q;
  assign count = count_q;
  assign flags = flags_q;
  assign reg_a = reg_a_q;
  assign reg_b = reg_b_q;

endmodule

// File: tb/tb_fp_div_goldschmidt_iter.sv
// Directed testbench for fp_div_goldschmidt_iter (single precision defaults).
module tb_fp_div_goldschmidt_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b, q;
  logic        busy, ready;
  logic [2:0]  count;
  logic [3:0]  flags;
  logic [33:0] reg_a, reg_b;

  int n_chk = 0;
  int n_err = 0;

`ifdef FPDIV_EARLY_OUT_EN
  localparam int SL = 1;
`else
  localparam int SL = 7;
`endif

  fp_div_goldschmidt_iter dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .q(q), .busy(busy), .ready(ready), .count(count), .flags(flags),
    .reg_a(reg_a), .reg_b(reg_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one start across the next rising edge.
  task automatic go(input logic [31:0] va, input logic [31:0] vb);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the start edge until ready; -1 if it never comes.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clock);
      #1;
      if (ready) lat = i;
    end
  endtask

  task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] exp_q, input logic [3:0] exp_f, input int exp_lat);
    int lat;
    @(negedge clock);
    go(va, vb);
    wait_ready(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_q"}, 64'(q), 64'(exp_q));
    chk({tag, "_flags"}, 64'(flags), 64'(exp_f));
    @(posedge clock);
    #1;
    chk({tag, "_pulse"}, 64'(ready), 64'(0));
  endtask

  initial begin
    int lat;
    logic seen;
    reset = 1'b1;
    start = 1'b0;
    a = 32'h0;
    b = 32'h0;

    // Reset held: start toggling must not produce anything.
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = ~start;
      a = 32'h40C00000;
      b = 32'h40000000;
      @(posedge clock);
      #1;
      if (ready) seen = 1'b1;
    end
    start = 1'b0;
    chk("rst_ready_seen", 64'(seen), 64'(0));
    chk("rst_q", 64'(q), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_flags", 64'(flags), 64'(0));
    chk("rst_reg_a", 64'(reg_a), 64'(0));
    chk("rst_reg_b", 64'(reg_b), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    // Main function and special operands.
    run("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 7);
    run("neg6_2",   32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 7);
    run("one_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 7);
    run("divzero",  32'hC0000000, 32'h80000000, 32'h7F800000, 4'b0100, SL);
    run("zero_zero",32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, SL);
    run("nan_in",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, SL);
    run("overflow", 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 7);
    run("underflow",32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 7);
    run("inf_fin",  32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, SL);
    run("fin_inf",  32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, SL);
    run("denorm",   32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, SL);

    // Start during busy is ignored; start in the ready cycle is accepted.
    @(negedge clock);
    go(32'h40C00000, 32'h40000000);
    repeat (2) @(posedge clock);
    #1;
    a = 32'h3F800000;
    b = 32'h3F800000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("ign_busy", 64'(busy), 64'(1));
    wait_ready(lat);
    chk("ign_lat", 64'(lat + 3), 64'(7));
    chk("ign_q", 64'(q), 64'(32'h40400000));
    chk("b2b_busy", 64'(busy), 64'(0));
    go(32'hC0C00000, 32'h40000000);
    wait_ready(lat);
    chk("b2b_lat", 64'(lat), 64'(7));
    chk("b2b_q", 64'(q), 64'(32'hC0400000));

    // Reset mid-operation aborts without a ready pulse.
    @(negedge clock);
    go(32'h40C00000, 32'h40000000);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_count", 64'(count), 64'(0));
    chk("abort_reg_a", 64'(reg_a), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (ready) seen = 1'b1;
    end
    chk("abort_no_ready", 64'(seen), 64'(0));

    // 1/3: within one ulp of the round-to-nearest result 0x3EAAAAAB.
    @(negedge clock);
    go(32'h3F800000, 32'h40400000);
    wait_ready(lat);
    chk("third_lat", 64'(lat), 64'(7));
    chk("third_ulp", 64'((q >= 32'h3EAAAAAA) && (q <= 32'h3EAAAAAC)), 64'(1));
    chk("third_flags", 64'(flags), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
